// File: rtl/csr_reg_pkg.sv
// -----------------------------------------------------------------------------
// csr_reg_pkg
// Shared definitions for the CSR register responder that sits behind the
// JTAG-to-AVMM bridge: register byte offsets, the pattern returned for
// unmapped reads, the read-FSM state encoding and a saturating increment.
//
// Optional feature macro: CSR_WR_COUNT_EN (adds the WR_COUNT register).
// -----------------------------------------------------------------------------
package csr_reg_pkg;

  // Byte offsets of the register map (address bits [1:0] are ignored).
  localparam logic [15:0] ADDR_VERSION  = 16'h0000;
  localparam logic [15:0] ADDR_CTRL     = 16'h0004;
  localparam logic [15:0] ADDR_STATUS   = 16'h0008;
  localparam logic [15:0] ADDR_STICKY   = 16'h000C;
  localparam logic [15:0] ADDR_SCRATCH0 = 16'h0010;
  localparam logic [15:0] ADDR_SCRATCH1 = 16'h0014;
  localparam logic [15:0] ADDR_SCRATCH2 = 16'h0018;
  localparam logic [15:0] ADDR_SCRATCH3 = 16'h001C;
  localparam logic [15:0] ADDR_WR_COUNT = 16'h0020;

  // Read data returned for any unmapped address.
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  // Read FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LAT  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } rd_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/csr_rd_pipe.sv
// -----------------------------------------------------------------------------
// csr_rd_pipe
// Read-response pacing for the CSR responder. A read is accepted only in IDLE,
// the read-mux value is snapshotted at accept, and the snapshot is presented on
// rd_dataout together with a one-cycle csr_rd_dvalid exactly RD_LAT cycles
// later. After the response the FSM ignores rd_en for HOLD_CYC cycles so the
// bridge's level-held, registered rd_en cannot launch a duplicate read.
//
// Parameters:
//   RD_LAT    cycles from accept to csr_rd_dvalid (1..4)
//   HOLD_CYC  cycles rd_en is ignored after the response (0..8)
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset (flushes any read in flight)
//   rd_en          read request level
//   mux_data       current read-mux value for the presented address
//   rd_dataout     response data, holds its value outside the response cycle
//   csr_rd_dvalid  one-cycle response strobe
//   rd_busy        high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module csr_rd_pipe
  import csr_reg_pkg::*;
#(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [31:0] mux_data,
  output logic [31:0] rd_dataout,
  output logic        csr_rd_dvalid,
  output logic        rd_busy
);

  // Counter preloads: LAT lasts RD_LAT-1 cycles, HOLD lasts HOLD_CYC cycles,
  // both counting down to zero inclusive.
  localparam logic [2:0] LAT_LOAD  = 3'(RD_LAT - 2);
  localparam logic [2:0] HOLD_LOAD = 3'(HOLD_CYC - 1);

  rd_state_e   state_q;
  logic [2:0]  cnt_q;
  logic [31:0] snap_q;
  logic [31:0] dout_q;
  logic        dvalid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      snap_q   <= 32'd0;
      dout_q   <= 32'd0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd_en) begin
            snap_q <= mux_data;
            if (RD_LAT == 1) begin
              // No latency stage: respond on the very next cycle.
              dout_q   <= mux_data;
              dvalid_q <= 1'b1;
              state_q  <= S_RESP;
            end else begin
              cnt_q   <= LAT_LOAD;
              state_q <= S_LAT;
            end
          end
        end
        S_LAT: begin
          if (cnt_q == 3'd0) begin
            dout_q   <= snap_q;
            dvalid_q <= 1'b1;
            state_q  <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (HOLD_CYC == 0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= HOLD_LOAD;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q == 3'd0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_dataout    = dout_q;
  assign csr_rd_dvalid = dvalid_q;
  assign rd_busy       = (state_q != S_IDLE);

endmodule

// File: rtl/csr_reg_responder.sv
// -----------------------------------------------------------------------------
// csr_reg_responder
// CSR target behind the JTAG-to-AVMM bridge. Decodes the bridge's address and
// write/read strobes, holds the register bank and hands read-mux data to
// csr_rd_pipe, which returns it with a fixed latency.
//
// Register map (byte offsets, bits [1:0] ignored):
//   0x0000 VERSION   RO
//   0x0004 CTRL      RW  (mirrored on ctrl_out)
//   0x0008 STATUS    RO  (status_in sampled at read accept)
//   0x000C STICKY    W1C (set by event_in; set beats clear)
//   0x0010..0x001C SCRATCH0..3 RW
//   0x0020 WR_COUNT  saturating count of mapped writes, cleared by any write
//                    (present only when CSR_WR_COUNT_EN is defined)
//   anything else    unmapped: reads return DEAD_BEEF, writes are dropped,
//                    err_unmapped pulses one cycle after the access
//
// Optional feature macro: CSR_WR_COUNT_EN.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   wr_rd_addr     byte address shared by reads and writes
//   wr_en          one write per cycle high
//   rd_en          read request level
//   wr_data        write data
//   status_in      live status
//   event_in       event pulses into STICKY
//   rd_dataout     read data
//   csr_rd_dvalid  one-cycle read-data-valid
//   ctrl_out       CTRL contents
//   err_unmapped   one-cycle pulse per unmapped access
//   rd_busy        read FSM not IDLE
// -----------------------------------------------------------------------------
module csr_reg_responder
  import csr_reg_pkg::*;
#(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned HOLD_CYC = 2,
  parameter logic [31:0] VERSION  = 32'h0001_0000,
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] wr_rd_addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wr_data,
  input  logic [31:0] status_in,
  input  logic [31:0] event_in,
  output logic [31:0] rd_dataout,
  output logic        csr_rd_dvalid,
  output logic [31:0] ctrl_out,
  output logic        err_unmapped,
  output logic        rd_busy
);

  logic [15:0] addr_w;
  logic        unused_addr_lsb;

  logic [31:0] ctrl_q,    ctrl_d;
  logic [31:0] sticky_q,  sticky_d;
  logic [31:0] scratch_q [4];
  logic [31:0] scratch_d [4];
  logic        err_q,     err_d;

  logic [31:0] mux_data;
  logic        mapped;
  logic        rd_accept;
  logic        pipe_busy;

`ifdef CSR_WR_COUNT_EN
  logic [31:0] wr_count_q, wr_count_d;
`endif

  // Word-align the address; the low byte-lane bits carry no meaning here.
  assign addr_w          = {wr_rd_addr[15:2], 2'b00};
  assign unused_addr_lsb = ^wr_rd_addr[1:0];

  // A read is taken only when the read pipe is idle.
  assign rd_accept = rd_en && !pipe_busy;

  // Read mux and address-mapped flag. The mux looks at current register
  // values, so a write in the accept cycle is not visible in the snapshot.
  always_comb begin
    mux_data = BAD_DATA;
    mapped   = 1'b1;
    case (addr_w)
      ADDR_VERSION:  mux_data = VERSION;
      ADDR_CTRL:     mux_data = ctrl_q;
      ADDR_STATUS:   mux_data = status_in;
      ADDR_STICKY:   mux_data = sticky_q;
      ADDR_SCRATCH0: mux_data = scratch_q[0];
      ADDR_SCRATCH1: mux_data = scratch_q[1];
      ADDR_SCRATCH2: mux_data = scratch_q[2];
      ADDR_SCRATCH3: mux_data = scratch_q[3];
`ifdef CSR_WR_COUNT_EN
      ADDR_WR_COUNT: mux_data = wr_count_q;
`endif
      default: begin
        mux_data = BAD_DATA;
        mapped   = 1'b0;
      end
    endcase
  end

  // Write decode and next-state for the register bank.
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    if (wr_en) begin
      case (addr_w)
        ADDR_CTRL:     ctrl_d       = wr_data;
        ADDR_SCRATCH0: scratch_d[0] = wr_data;
        ADDR_SCRATCH1: scratch_d[1] = wr_data;
        ADDR_SCRATCH2: scratch_d[2] = wr_data;
        ADDR_SCRATCH3: scratch_d[3] = wr_data;
        default: ;
      endcase
    end
    // Clear first, then OR in events, so a coincident event keeps its bit set.
    sticky_d = (sticky_q & ~((wr_en && addr_w == ADDR_STICKY) ? wr_data : 32'd0))
             | event_in;
    // Both access types share the address, so a same-cycle read and write to
    // one unmapped address produce a single pulse.
    err_d = (wr_en || rd_accept) && !mapped;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q   <= CTRL_RST;
      sticky_q <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        scratch_q[i] <= 32'd0;
      end
      err_q    <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      sticky_q  <= sticky_d;
      scratch_q <= scratch_d;
      err_q     <= err_d;
    end
  end

`ifdef CSR_WR_COUNT_EN
  // A write to WR_COUNT clears it and is not itself counted.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_en && addr_w == ADDR_WR_COUNT) begin
      wr_count_d = 32'd0;
    end else if (wr_en && mapped) begin
      wr_count_d = sat_inc32(wr_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_q <= 32'd0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end
`endif

  csr_rd_pipe #(
    .RD_LAT   (RD_LAT),
    .HOLD_CYC (HOLD_CYC)
  ) u_rd_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_en         (rd_en),
    .mux_data      (mux_data),
    .rd_dataout    (rd_dataout),
    .csr_rd_dvalid (csr_rd_dvalid),
    .rd_busy       (pipe_busy)
  );

  assign rd_busy      = pipe_busy;
  assign ctrl_out     = ctrl_q;
  assign err_unmapped = err_q;

endmodule

// File: tb/tb_csr_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_csr_reg_responder
// Directed bench for csr_reg_responder with RD_LAT=2, HOLD_CYC=2.
// Inputs change 1 time unit after the rising edge; outputs are looked at at
// the same point, so each "tick" is one clock cycle later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csr_reg_responder;

  localparam logic [31:0] VERSION_VAL = 32'h0001_0000;
  localparam logic [31:0] CTRL_RST_V  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_rd_addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic [31:0] status_in;
  logic [31:0] event_in;
  logic [31:0] rd_dataout;
  logic        csr_rd_dvalid;
  logic [31:0] ctrl_out;
  logic        err_unmapped;
  logic        rd_busy;

  int checks = 0;
  int errors = 0;

  csr_reg_responder #(
    .RD_LAT   (2),
    .HOLD_CYC (2),
    .VERSION  (VERSION_VAL),
    .CTRL_RST (CTRL_RST_V)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_rd_addr    (wr_rd_addr),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .wr_data       (wr_data),
    .status_in     (status_in),
    .event_in      (event_in),
    .rd_dataout    (rd_dataout),
    .csr_rd_dvalid (csr_rd_dvalid),
    .ctrl_out      (ctrl_out),
    .err_unmapped  (err_unmapped),
    .rd_busy       (rd_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    wr_rd_addr = a;
    wr_data    = d;
    wr_en      = 1'b1;
    tick();
    wr_en      = 1'b0;
  endtask

  // Issues a one-cycle rd_en (optionally with a same-cycle write), then waits
  // a bounded number of cycles for dvalid. lat = cycles from the request
  // cycle to dvalid (-1 on timeout); dv_after = dvalid one cycle later;
  // errs = err_unmapped pulses seen. Leaves the FSM back in IDLE.
  task automatic do_read(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                         output logic [31:0] d, output int lat,
                         output logic dv_after, output int errs);
    wr_rd_addr = a;
    rd_en      = 1'b1;
    wr_en      = wr;
    wr_data    = wd;
    tick();
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    lat      = -1;
    d        = 32'd0;
    errs     = 0;
    dv_after = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (err_unmapped) errs++;
      if (csr_rd_dvalid) begin
        lat = i;
        d   = rd_dataout;
        break;
      end
      tick();
    end
    tick();
    dv_after = csr_rd_dvalid;
    if (err_unmapped) errs++;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (ctrl_out !== CTRL_RST_V) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", ctrl_out, CTRL_RST_V); end
    checks++; if (rd_dataout !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rd_dataout); end
    checks++; if (csr_rd_dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", csr_rd_dvalid); end
    checks++; if (err_unmapped !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_unmapped); end
    checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rd_busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ctrl_rw();
    logic [31:0] d; int lat; logic dva; int errs;
    do_write(16'h0004, 32'hA5A5_0001);
    checks++; if (ctrl_out !== 32'hA5A5_0001) begin errors++; $display("FAIL ctrl_out_after_write: got %h expected a5a50001", ctrl_out); end
    do_read(16'h0004, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ctrl_read_latency: got %0d expected 2", lat); end
    checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL ctrl_read_data: got %h expected a5a50001", d); end
    checks++; if (dva !== 1'b0) begin errors++; $display("FAIL ctrl_dvalid_width: got %b expected 0", dva); end
    checks++; if (rd_dataout !== 32'hA5A5_0001) begin errors++; $display("FAIL ctrl_rdata_hold: got %h expected a5a50001", rd_dataout); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL ctrl_read_err: got %0d expected 0", errs); end
    // Byte-lane bits are ignored: 0x0007 aliases CTRL.
    do_read(16'h0007, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL ctrl_alias_data: got %h expected a5a50001", d); end
  endtask

  task automatic test_level_read();
    logic [9:0]  obs;
    logic [31:0] d1, d2;
    logic        busy1;
    obs = '0; d1 = '0; d2 = '0; busy1 = 1'b0;
    wr_rd_addr = 16'h0000;
    rd_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) rd_en = 1'b0;
      if (i == 1) busy1 = rd_busy;
      if (csr_rd_dvalid) begin
        obs[i-1] = 1'b1;
        if (i == 2) d1 = rd_dataout;
        if (i == 7) d2 = rd_dataout;
      end
    end
    checks++; if (obs !== 10'b00_0100_0010) begin errors++; $display("FAIL level_dvalid_pattern: got %b expected 0001000010", obs); end
    checks++; if (d1 !== VERSION_VAL) begin errors++; $display("FAIL level_first_data: got %h expected %h", d1, VERSION_VAL); end
    checks++; if (d2 !== VERSION_VAL) begin errors++; $display("FAIL level_second_data: got %h expected %h", d2, VERSION_VAL); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL level_busy_in_lat: got %b expected 1", busy1); end
    checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL level_busy_end: got %b expected 0", rd_busy); end
  endtask

  task automatic test_sticky();
    logic [31:0] d; int lat; logic dva; int errs;
    event_in = 32'h0000_0011;
    tick();
    event_in = 32'h0000_0001;
    do_write(16'h000C, 32'h0000_0001);
    event_in = 32'h0000_0000;
    do_read(16'h000C, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'h0000_0011) begin errors++; $display("FAIL sticky_set_wins: got %h expected 00000011", d); end
    do_write(16'h000C, 32'h0000_0010);
    do_read(16'h000C, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL sticky_w1c: got %h expected 00000001", d); end
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] d; int lat; logic dva; int errs;
    do_read(16'h0018, 1'b1, 32'h0000_1234, d, lat, dva, errs);
    checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL same_cycle_old_value: got %h expected 00000000", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL same_cycle_latency: got %0d expected 2", lat); end
    do_read(16'h0018, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL same_cycle_new_value: got %h expected 00001234", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; int lat; logic dva; int errs;
    do_read(16'h0030, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped_read_data: got %h expected deadbeef", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL unmapped_read_latency: got %0d expected 2", lat); end
    checks++; if (errs !== 1) begin errors++; $display("FAIL unmapped_read_err_count: got %0d expected 1", errs); end
    wr_rd_addr = 16'h0030; wr_data = 32'hFFFF_FFFF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++; if (err_unmapped !== 1'b1) begin errors++; $display("FAIL unmapped_write_err: got %b expected 1", err_unmapped); end
    tick();
    checks++; if (err_unmapped !== 1'b0) begin errors++; $display("FAIL unmapped_write_err_width: got %b expected 0", err_unmapped); end
    checks++; if (ctrl_out !== 32'hA5A5_0001) begin errors++; $display("FAIL unmapped_write_ctrl: got %h expected a5a50001", ctrl_out); end
    do_read(16'h0018, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL unmapped_write_scratch: got %h expected 00001234", d); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL mapped_read_err: got %0d expected 0", errs); end
    // RO register: write ignored, no error pulse.
    do_write(16'h0000, 32'hFFFF_FFFF);
    checks++; if (err_unmapped !== 1'b0) begin errors++; $display("FAIL ro_write_err: got %b expected 0", err_unmapped); end
    do_read(16'h0000, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== VERSION_VAL) begin errors++; $display("FAIL ro_write_ignored: got %h expected %h", d, VERSION_VAL); end
    status_in = 32'hCAFE_0001;
    do_read(16'h0008, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL status_read: got %h expected cafe0001", d); end
`ifndef CSR_WR_COUNT_EN
    do_read(16'h0020, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_count_absent_data: got %h expected deadbeef", d); end
    checks++; if (errs !== 1) begin errors++; $display("FAIL wr_count_absent_err: got %0d expected 1", errs); end
`endif
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d; int lat; logic dva; int errs;
    int dv_seen;
    do_write(16'h0010, 32'h0000_0055);
    wr_rd_addr = 16'h0004;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_busy !== 1'b1) begin errors++; $display("FAIL inflight_busy: got %b expected 1", rd_busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dv_seen = (csr_rd_dvalid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (csr_rd_dvalid === 1'b1) dv_seen++;
    end
    checks++; if (dv_seen !== 0) begin errors++; $display("FAIL inflight_no_dvalid: got %0d expected 0", dv_seen); end
    checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL inflight_busy_after_reset: got %b expected 0", rd_busy); end
    checks++; if (ctrl_out !== CTRL_RST_V) begin errors++; $display("FAIL inflight_ctrl_reset: got %h expected %h", ctrl_out, CTRL_RST_V); end
    checks++; if (rd_dataout !== 32'd0) begin errors++; $display("FAIL inflight_rdata_reset: got %h expected 00000000", rd_dataout); end
    do_read(16'h0010, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL inflight_scratch0_reset: got %h expected 00000000", d); end
    do_read(16'h0018, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL inflight_scratch2_reset: got %h expected 00000000", d); end
    do_read(16'h000C, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL inflight_sticky_reset: got %h expected 00000000", d); end
`ifdef CSR_WR_COUNT_EN
    do_read(16'h0020, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL wr_count_reset: got %h expected 00000000", d); end
    do_write(16'h0014, 32'h1);
    do_write(16'h0014, 32'h2);
    do_write(16'h0004, 32'h3);
    do_read(16'h0020, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL wr_count_three: got %h expected 00000003", d); end
    do_write(16'h0020, 32'h1234_5678);
    do_read(16'h0020, 1'b0, 32'd0, d, lat, dva, errs);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL wr_count_clear: got %h expected 00000000", d); end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_rd_addr = 16'h0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_data    = 32'h0;
    status_in  = 32'h0;
    event_in   = 32'h0;
    test_reset();
    test_ctrl_rw();
    test_level_read();
    test_sticky();
    test_same_cycle_write();
    test_unmapped();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
